// File: rtl/mfcc_pkg.sv
// Shared types and constants for the MFCC front end: sample/coefficient types,
// Q15 rounding, default framing geometry and the Hamming coefficient generator.
package mfcc_pkg;

    typedef logic signed [15:0] sample_t;
    typedef logic        [15:0] coef_t;

    localparam int  Q15_ROUND     = 16384;
    localparam int  DEF_FRAME_LEN = 256;
    localparam int  DEF_HOP       = 128;
    localparam real PI            = 3.14159265358979323846;

    typedef enum logic {
        FW_IDLE,
        FW_EMIT
    } fw_state_t;

    // Evaluated at elaboration only; the result is a constant ROM word.
    function automatic coef_t hamming_coef(input int n, input int len);
        real w;
        w = 32767.0 * (0.54 - 0.46 * $cos(2.0 * PI * real'(n) / real'(len - 1)));
        return coef_t'($rtoi(w + 0.5));
    endfunction

endpackage

// File: rtl/window_rom.sv
// Hamming window coefficient ROM, unsigned Q15, one registered read per cycle.
module window_rom
    import mfcc_pkg::*;
#(
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic                         clk,
    input  logic [$clog2(FRAME_LEN)-1:0] addr,
    output coef_t                        coef
);

    coef_t table_w [FRAME_LEN];

    for (genvar i = 0; i < FRAME_LEN; i++) begin : g_rom
        localparam coef_t C = hamming_coef(i, FRAME_LEN);
        assign table_w[i] = C;
    end

    always_ff @(posedge clk) begin
        coef <= table_w[addr];
    end

endmodule

// File: rtl/framing_window.sv
// Collects the pre-emphasised stream into overlapping frames and emits each frame
// as a contiguous Hamming-windowed burst for the FFT stage.
module framing_window
    import mfcc_pkg::*;
#(
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int HOP       = DEF_HOP
) (
    input  logic    clk,
    input  logic    rst,
    input  sample_t preemph_out,
    input  logic    preemph_valid,
    output sample_t win_out,
    output logic    win_valid,
    output logic    frame_start,
    output logic    frame_end,
    output logic    overrun
);

    localparam int DEPTH = 2 * FRAME_LEN;
    localparam int AW    = $clog2(DEPTH);
    localparam int NW    = $clog2(FRAME_LEN);

    localparam logic [NW-1:0] N_LAST    = NW'(FRAME_LEN - 1);
    localparam logic [NW-1:0] HOP_LAST  = NW'(HOP - 1);
    localparam logic [AW-1:0] FRAME_OFS = AW'(FRAME_LEN);

    sample_t       mem [DEPTH];
    logic [AW-1:0] wptr, wptr_nxt, due_base, rd_base, pend_base, rd_addr;
    logic [NW-1:0] fill_cnt, n;
    logic          primed, due, pend, rd_en;
    fw_state_t     state;

    sample_t       rd_data;
    coef_t         rd_coef;
    logic          [2:1] vld_pipe, sof_pipe, eof_pipe;
    logic signed   [31:0] prod, rnd;

    // Before the first frame the counter measures a full frame, afterwards a hop.
    assign wptr_nxt = wptr + AW'(1);
    assign due      = preemph_valid && (fill_cnt == (primed ? HOP_LAST : N_LAST));
    assign due_base = wptr_nxt - FRAME_OFS;
    assign rd_en    = (state == FW_EMIT);
    assign rd_addr  = rd_base + AW'(n);

    always_ff @(posedge clk) begin
        if (preemph_valid) mem[wptr] <= preemph_out;
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            fill_cnt <= '0;
            primed   <= 1'b0;
        end else if (preemph_valid) begin
            wptr     <= wptr_nxt;
            fill_cnt <= due ? '0 : fill_cnt + NW'(1);
            if (due) primed <= 1'b1;
        end
    end

    // n wraps to zero after the last read since FRAME_LEN is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FW_IDLE;
            n         <= '0;
            rd_base   <= '0;
            pend      <= 1'b0;
            pend_base <= '0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                FW_IDLE: begin
                    n <= '0;
                    if (due) begin
                        rd_base <= due_base;
                        state   <= FW_EMIT;
                    end
                end
                FW_EMIT: begin
                    n <= n + NW'(1);
                    if (n == N_LAST) begin
                        // Pending flag is still set on the last read, so a
                        // coincident due is dropped rather than queued.
                        if (pend) begin
                            rd_base <= pend_base;
                            pend    <= 1'b0;
                            if (due) overrun <= 1'b1;
                        end else if (due) begin
                            rd_base <= due_base;
                        end else begin
                            state <= FW_IDLE;
                        end
                    end else if (due) begin
                        if (pend) begin
                            overrun <= 1'b1;
                        end else begin
                            pend      <= 1'b1;
                            pend_base <= due_base;
                        end
                    end
                end
                default: state <= FW_IDLE;
            endcase
        end
    end

    window_rom #(.FRAME_LEN(FRAME_LEN)) u_rom (
        .clk  (clk),
        .addr (n),
        .coef (rd_coef)
    );

    assign prod = 32'(rd_data) * 32'(signed'({1'b0, rd_coef}));
    assign rnd  = prod + Q15_ROUND;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            sof_pipe <= '0;
            eof_pipe <= '0;
            win_out  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], rd_en};
            sof_pipe <= {sof_pipe[1], rd_en && (n == '0)};
            eof_pipe <= {eof_pipe[1], rd_en && (n == N_LAST)};
            if (vld_pipe[1]) win_out <= sample_t'(rnd >>> 15);
        end
    end

    assign win_valid   = vld_pipe[2];
    assign frame_start = sof_pipe[2];
    assign frame_end   = eof_pipe[2];

endmodule

// File: tb/tb_framing_window.sv
// Scoreboard bench for framing_window: a default 256/128 instance and an 8/8 instance.
module tb_framing_window;
    import mfcc_pkg::*;

    localparam int FA = 256, HA = 128, FB = 8, HB = 8;

    typedef struct {
        int cyc;
        int lo;
        int hi;
        bit sof;
        bit eof;
    } exp_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    sample_t in_a = '0, in_b = '0;
    logic    vld_a = 1'b0, vld_b = 1'b0;
    sample_t win_a, win_b;
    logic    wv_a, wv_b, fs_a, fs_b, fe_a, fe_b, ov_a, ov_b;

    int cyc = 0;
    int vecs = 0, errs = 0;
    int sent [2];
    int last_first [2];
    int last_last [2];
    bit exp_ovr [2];
    int nframes [2];
    int mon_n [2];
    int coef8 [8] = '{2621, 8296, 21048, 31274, 31274, 21048, 8296, 2621};
    sample_t hist_a[$], hist_b[$];
    exp_t sbq_a[$], sbq_b[$];

    framing_window u_a (
        .clk(clk), .rst(rst), .preemph_out(in_a), .preemph_valid(vld_a),
        .win_out(win_a), .win_valid(wv_a), .frame_start(fs_a), .frame_end(fe_a), .overrun(ov_a)
    );

    framing_window #(.FRAME_LEN(FB), .HOP(HB)) u_b (
        .clk(clk), .rst(rst), .preemph_out(in_b), .preemph_valid(vld_b),
        .win_out(win_b), .win_valid(wv_b), .frame_start(fs_b), .frame_end(fe_b), .overrun(ov_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        vecs++;
        if (act != expv) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            sent[i] = 0; last_first[i] = 0; last_last[i] = -10; exp_ovr[i] = 0;
        end
        hist_a.delete(); hist_b.delete(); sbq_a.delete(); sbq_b.delete();
    endtask

    // Called in the cycle a sample is presented; pushes a whole frame when one is due.
    task automatic accept(input int id, input sample_t v);
        int f, h, r, s, a, m;
        exp_t e;
        f = id ? FB : FA;
        h = id ? HB : HA;
        if (id == 0) hist_a.push_back(v); else hist_b.push_back(v);
        sent[id]++;
        if (sent[id] < f || (sent[id] - f) % h != 0) return;
        if (last_first[id] > cyc) begin
            exp_ovr[id] = 1;
            return;
        end
        r = (cyc + 1 > last_last[id] + 1) ? cyc + 1 : last_last[id] + 1;
        last_first[id] = r;
        last_last[id]  = r + f - 1;
        for (int n = 0; n < f; n++) begin
            e.cyc = r + 2 + n;
            e.sof = (n == 0);
            e.eof = (n == f - 1);
            if (id == 1) begin
                s = int'(hist_b[sent[id] - f + n]);
                a = (s * coef8[n] + 16384) >>> 15;
                e.lo = a; e.hi = a;
                sbq_b.push_back(e);
            end else begin
                s = int'(hist_a[sent[id] - f + n]);
                a = (s * 2621 + 16384) >>> 15;
                if (n == 0 || n == f - 1) begin
                    e.lo = a; e.hi = a;
                end else if (n == f / 2 - 1 || n == f / 2) begin
                    m = (s * 32766) / 32768;
                    e.lo = m - 2; e.hi = m + 2;
                end else begin
                    e.lo = (a < s) ? a : s;
                    e.hi = (a < s) ? s : a;
                end
                sbq_a.push_back(e);
            end
        end
    endtask

    task automatic monitor(input int id);
        exp_t e;
        logic v, fs, fe;
        int w;
        bit have;
        forever begin
            @(negedge clk);
            v  = id ? wv_b : wv_a;
            fs = id ? fs_b : fs_a;
            fe = id ? fe_b : fe_a;
            w  = id ? int'(win_b) : int'(win_a);
            if (v) begin
                if (fs) begin nframes[id]++; mon_n[id] = 0; end
                else mon_n[id]++;
                vecs++;
                have = id ? (sbq_b.size() > 0) : (sbq_a.size() > 0);
                if (!have) begin
                    errs++;
                    $display("FAIL out%0d_unexpected: got valid %0d sof=%0b eof=%0b at cycle %0d, expected no output",
                             id, w, fs, fe, cyc);
                end else begin
                    if (id == 1) e = sbq_b.pop_front(); else e = sbq_a.pop_front();
                    if (cyc != e.cyc || w < e.lo || w > e.hi || fs != e.sof || fe != e.eof) begin
                        errs++;
                        $display("FAIL out%0d_n%0d: got %0d sof=%0b eof=%0b at cycle %0d, expected [%0d..%0d] sof=%0b eof=%0b at cycle %0d",
                                 id, mon_n[id], w, fs, fe, cyc, e.lo, e.hi, e.sof, e.eof, e.cyc);
                    end
                end
            end
        end
    endtask

    task automatic drive(input int id, input bit en, input sample_t v);
        @(posedge clk); #1;
        vld_a = (id == 0) && en;
        vld_b = (id == 1) && en;
        in_a  = (id == 0) ? v : '0;
        in_b  = (id == 1) ? v : '0;
        if (en) accept(id, v);
    endtask

    task automatic send(input int id, input sample_t v, input int period);
        drive(id, 1'b1, v);
        repeat (period - 1) drive(id, 1'b0, '0);
    endtask

    task automatic drain();
        drive(0, 1'b0, '0);
        for (int k = 0; k < 3000 && (sbq_a.size() + sbq_b.size()) > 0; k++) begin
            @(negedge clk); #1;
        end
        chk("drain_outstanding", sbq_a.size() + sbq_b.size(), 0);
        repeat (4) drive(0, 1'b0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; vld_a = 1'b0; vld_b = 1'b0; in_a = '0; in_b = '0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int nf;
        bit found;
        model_reset();
        nframes = '{0, 0};
        mon_n   = '{0, 0};
        fork
            monitor(0);
            monitor(1);
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_win_out", int'(win_a), 0);
        chk("rst_win_valid", wv_a, 0);
        chk("rst_frame_start", fs_a, 0);
        chk("rst_frame_end", fe_a, 0);
        chk("rst_overrun", ov_a, 0);
        chk("rst_overrun_b", ov_b, 0);
        rst = 1'b0;

        // Constant 0x4000, one sample per 4 cycles: single frame.
        nf = nframes[0];
        for (int i = 0; i < 256; i++) send(0, 16'sh4000, 4);
        drain();
        chk("const_frames", nframes[0] - nf, 1);

        // Ramp: frames at 256, 384, 512 samples.
        do_reset();
        nf = nframes[0];
        for (int i = 0; i < 512; i++) send(0, sample_t'(i), 4);
        drain();
        chk("ramp_frames", nframes[0] - nf, 3);

        // Negative full scale.
        do_reset();
        for (int i = 0; i < 256; i++) send(0, 16'sh8000, 4);
        drain();
        chk("negfs_overrun", ov_a, 0);

        // Every-cycle input: 384 pends, 512 is dropped, 640 pends after that.
        do_reset();
        nf = nframes[0];
        for (int i = 0; i < 700; i++) begin
            send(0, sample_t'(i), 1);
            if (i == 499) chk("overrun_before_drop", ov_a, 0);
            if (i == 530) chk("overrun_after_drop", ov_a, 1);
        end
        drain();
        chk("overrun_sticky", ov_a, 1);
        chk("overrun_model", ov_a, int'(exp_ovr[0]));
        chk("fullrate_frames", nframes[0] - nf, 3);

        // Reset in the middle of a burst at n = 100.
        do_reset();
        chk("overrun_cleared", ov_a, 0);
        for (int i = 0; i < 256; i++) send(0, 16'sh4000, 4);
        found = 0;
        for (int k = 0; k < 600 && !found; k++) begin
            @(negedge clk); #1;
            if (wv_a && mon_n[0] == 100) found = 1;
        end
        chk("reached_n100", int'(found), 1);
        rst = 1'b1;
        model_reset();
        @(negedge clk); #1;
        chk("midrst_win_valid", wv_a, 0);
        chk("midrst_frame_end", fe_a, 0);
        chk("midrst_win_out", int'(win_a), 0);
        rst = 1'b0;
        nf = nframes[0];
        for (int i = 0; i < 255; i++) send(0, 16'sh4000, 2);
        repeat (10) drive(0, 1'b0, '0);
        chk("midrst_no_early_frame", nframes[0] - nf, 0);
        send(0, 16'sh4000, 2);
        drain();
        chk("midrst_fresh_frame", nframes[0] - nf, 1);

        // FRAME_LEN = HOP = 8: non-overlapping frames, exact values.
        do_reset();
        nf = nframes[1];
        begin
            sample_t vals [16];
            vals = '{16'sd1000, -16'sd1000, 16'sd20000, -16'sd20000, 16'sd32767, -16'sd32768, 16'sd7, -16'sd7,
                     16'sd100, 16'sd200, 16'sd300, 16'sd400, 16'sd500, 16'sd600, 16'sd700, 16'sd800};
            for (int i = 0; i < 16; i++) send(1, vals[i], 16);
        end
        drain();
        chk("small_frames", nframes[1] - nf, 2);
        chk("small_overrun", ov_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
